// File: rtl/aes_128_sub_bytes_if.sv
// aes_128_sub_bytes handshake bundle.
// master = state producer/consumer side, slave = sequencer.
interface aes_128_sub_bytes_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/aes_128_sub_bytes.sv
// SubBytes sequencer: two sbox lookups per cycle, 16 bytes reassembled.
// Optional macro AES_128_SUBBYTES_BYPASS_EN adds a bypass input.
module aes_128_sub_bytes #(
  parameter int BYTES_PER_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef AES_128_SUBBYTES_BYPASS_EN
  input  logic                  bypass,
`endif
  aes_128_sub_bytes_if.slave    bus,
  output logic [7:0]            sbox_addra,
  output logic [7:0]            sbox_addrb,
  output logic                  sbox_kill,
  input  logic [7:0]            sbox_doa,
  input  logic [7:0]            sbox_dob
);

  localparam int NBYTES = 16;

  if (BYTES_PER_CYC != 2) begin : g_bad_cfg
    $error("aes_128_sub_bytes: BYTES_PER_CYC must be 2");
  end

  if (NBYTES != 8 * BYTES_PER_CYC) begin : g_bad_nbytes
    $error("aes_128_sub_bytes: NBYTES must be 16");
  end

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]   state;
  logic [2:0]   cnt;
  logic         cap_vld;
  logic [2:0]   cap_idx;
  logic [127:0] state_reg;
  logic [127:0] out_q;
  logic         out_v;
  logic [2:0]   pidx;

  // byte i of a state, byte 0 in the MSBs
  function automatic logic [7:0] sel(
    input logic [127:0] s,
    input logic [3:0]   i
  );
    logic [127:0] t;
    t = s << {i, 3'b000};
    return t[127:120];
  endfunction

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_v;
  assign bus.out_state = out_q;

  // sbox addressing; DRAIN keeps presenting the last pair
  always_comb begin
    pidx       = (state == DRAIN) ? 3'd7 : cnt;
    sbox_kill  = 1'b1;
    sbox_addra = 8'h00;
    sbox_addrb = 8'h00;
    if (state == ISSUE || state == DRAIN) begin
      sbox_kill  = 1'b0;
      sbox_addra = sel(state_reg, {pidx, 1'b0});
      sbox_addrb = sel(state_reg, {pidx, 1'b1});
    end
  end

  // FSM, issue counter and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      cap_vld   <= 1'b0;
      cap_idx   <= 3'd0;
      state_reg <= '0;
      out_q     <= '0;
      out_v     <= 1'b0;
    end else begin
      cap_vld <= 1'b0;
      if (cap_vld) begin
        out_q[7'd127 - {cap_idx, 4'b0000} -: 16] <=
          {sbox_doa, sbox_dob};
      end
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state_reg <= bus.in_state;
            cnt       <= 3'd0;
`ifdef AES_128_SUBBYTES_BYPASS_EN
            if (bypass) begin
              out_q <= bus.in_state;
              out_v <= 1'b1;
              state <= DONE;
            end else begin
              state <= ISSUE;
            end
`else
            state <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          cap_vld <= 1'b1;
          cap_idx <= cnt;
          cnt     <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          out_v <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_v <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_128_sub_bytes.sv
// Directed bench for aes_128_sub_bytes with a behavioural sbox.
// Table covers bytes 00-1f (encrypt) and their inverses (decrypt).
module tb_aes_128_sub_bytes;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sbox_addra, sbox_addrb;
  logic       sbox_kill;
  logic [7:0] sbox_doa = 8'h00;
  logic [7:0] sbox_dob = 8'h00;
  logic       dec = 1'b0;
`ifdef AES_128_SUBBYTES_BYPASS_EN
  logic       bypass = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc[$];
  logic [127:0] outs[$];

  aes_128_sub_bytes_if bus();

  aes_128_sub_bytes dut (
    .clk        (clk),
    .rst        (rst),
`ifdef AES_128_SUBBYTES_BYPASS_EN
    .bypass     (bypass),
`endif
    .bus        (bus),
    .sbox_addra (sbox_addra),
    .sbox_addrb (sbox_addrb),
    .sbox_kill  (sbox_kill),
    .sbox_doa   (sbox_doa),
    .sbox_dob   (sbox_dob)
  );

  always #5 clk = ~clk;

  logic [7:0] fwd [32] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0
  };

  function automatic logic [7:0] lut(input logic [7:0] a);
    logic [7:0] r;
    r = a ^ 8'h5a;
    if (!dec) begin
      if (a < 8'd32) r = fwd[a[4:0]];
    end else begin
      for (int i = 0; i < 32; i++)
        if (fwd[i] == a) r = 8'(i);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (sbox_kill) begin
      sbox_doa <= 8'h00;
      sbox_dob <= 8'h00;
    end else begin
      sbox_doa <= lut(sbox_addra);
      sbox_dob <= lut(sbox_addrb);
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && bus.in_valid && bus.in_ready)
      acc_cyc.push_back(cyc);
    if (!rst && bus.out_valid && bus.out_ready)
      outs.push_back(bus.out_state);
  end

  localparam logic [127:0] PT0 =
    128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] CT0 =
    128'h637c777b_f26b6fc5_3001672b_fed7ab76;
  localparam logic [127:0] PT1 =
    128'h10111213_14151617_18191a1b_1c1d1e1f;
  localparam logic [127:0] CT1 =
    128'hca82c97d_fa5947f0_add4a2af_9ca472c0;

  // offers s; lat = cycle (accept cycle = 0) where out_valid is seen
  task automatic run_block(
    input  logic [127:0] s,
    output logic [127:0] res,
    output int           lat
  );
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_state = s;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = bus.out_state;
  endtask

  task automatic idle_wait();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0",
               bus.in_ready, bus.out_valid);
    end
    total++;
    if (bus.out_state !== 128'h0) begin
      bad++;
      $display("FAIL reset_out: got %h want 0", bus.out_state);
    end
    total++;
    if (sbox_kill !== 1'b1 || sbox_addra !== 8'h00 ||
        sbox_addrb !== 8'h00) begin
      bad++;
      $display("FAIL reset_sbox: kill=%b a=%h b=%h want 1/00/00",
               sbox_kill, sbox_addra, sbox_addrb);
    end
    rst = 1'b0;
  endtask

  task automatic test_encrypt();
    int lat;
    dec = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_state = PT0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (sbox_kill !== 1'b0 || sbox_addra !== 8'h00 ||
        sbox_addrb !== 8'h01 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL enc_issue0: kill=%b a=%h b=%h rdy=%b want 0/00/01/0",
               sbox_kill, sbox_addra, sbox_addrb, bus.in_ready);
    end
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== 10) begin
      bad++;
      $display("FAIL enc_latency: got %0d want 10", lat);
    end
    total++;
    if (bus.out_state !== CT0) begin
      bad++;
      $display("FAIL enc_data: got %h want %h", bus.out_state, CT0);
    end
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL enc_pulse: out_valid=%b in_ready=%b want 0/1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_decrypt();
    logic [127:0] r;
    int lat;
    dec = 1'b1;
    bus.out_ready = 1'b1;
    run_block(CT0, r, lat);
    total++;
    if (r !== PT0 || lat !== 10) begin
      bad++;
      $display("FAIL dec_data: got %h lat %0d want %h lat 10",
               r, lat, PT0);
    end
    dec = 1'b0;
    idle_wait();
  endtask

  task automatic test_backpressure();
    logic [127:0] r;
    int lat;
    int errs;
    bus.out_ready = 1'b0;
    run_block(PT1, r, lat);
    total++;
    if (r !== CT1) begin
      bad++;
      $display("FAIL bp_data: got %h want %h", r, CT1);
    end
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_state !== CT1 ||
          bus.in_ready !== 1'b0) begin
        bad++;
        if (errs < 3)
          $display("FAIL bp_hold[%0d]: v=%b rdy=%b d=%h want 1/0/%h",
                   i, bus.out_valid, bus.in_ready, bus.out_state, CT1);
        errs++;
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    acc_cyc.delete();
    outs.delete();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_state = PT0;
    n = 0;
    while (acc_cyc.size() < 1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    bus.in_state = PT1;
    n = 0;
    while (acc_cyc.size() < 2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    n = 0;
    while (outs.size() < 2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (acc_cyc.size() != 2) begin
      bad++;
      $display("FAIL b2b_accepts: got %0d want 2", acc_cyc.size());
    end else begin
      total++;
      if (acc_cyc[1] - acc_cyc[0] != 11) begin
        bad++;
        $display("FAIL b2b_spacing: got %0d want 11",
                 acc_cyc[1] - acc_cyc[0]);
      end
    end
    total++;
    if (outs.size() != 2) begin
      bad++;
      $display("FAIL b2b_outs: got %0d want 2", outs.size());
    end else begin
      total++;
      if (outs[0] !== CT0 || outs[1] !== CT1) begin
        bad++;
        $display("FAIL b2b_data: got %h %h want %h %h",
                 outs[0], outs[1], CT0, CT1);
      end
    end
    idle_wait();
  endtask

  task automatic test_reset_mid();
    logic [127:0] r;
    int lat;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_state = PT0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.out_state !== 128'h0 || sbox_kill !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid: v=%b rdy=%b kill=%b d=%h want 0/1/1/0",
               bus.out_valid, bus.in_ready, sbox_kill, bus.out_state);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL rst_no_pulse: out_valid=%b want 0",
                 bus.out_valid);
      end
    end
    run_block(PT1, r, lat);
    total++;
    if (r !== CT1 || lat !== 10) begin
      bad++;
      $display("FAIL rst_next: got %h lat %0d want %h lat 10",
               r, lat, CT1);
    end
    idle_wait();
  endtask

`ifdef AES_128_SUBBYTES_BYPASS_EN
  task automatic test_bypass();
    logic [127:0] s;
    s = 128'hffeeddcc_bbaa9988_77665544_33221100;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bypass = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_state = s;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bypass = 1'b0;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_state !== s ||
        sbox_kill !== 1'b1) begin
      bad++;
      $display("FAIL bypass: v=%b kill=%b d=%h want 1/1/%h",
               bus.out_valid, sbox_kill, bus.out_state, s);
    end
    idle_wait();
  endtask
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef AES_128_SUBBYTES_BYPASS_EN
    test_bypass();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
